toggle_decoder: RTL

Receives a toggle-encoded event line (each logical event is one level change, as produced by the T flip-flop chains driving the toy's actuator/sensor wiring), synchronizes it into the system clock domain, and rejects glitches with a debounce filter. Each confirmed toggle produces a one-cycle event pulse, a pending flag held until acknowledged, and an increment of an event counter. It sits between the toggle-line sources and the control FSMs that consume discrete events.

---
 rtl/toggle_decoder_pkg.sv | 15 +
 rtl/toggle_decoder_sync_chain.sv | 22 ++
 rtl/toggle_decoder.sv | 119 +++++++++++
 3 files changed

// File: rtl/toggle_decoder_pkg.sv
// Shared types and default parameter values for the toggle-line decoder.
// Debounce FSM states are only used when TOGGLE_DECODER_DEBOUNCE_EN is defined.
package toggle_decoder_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CONFIRM = 1'b1
  } state_t;

  localparam int   DEF_SYNC_STAGES     = 2;
  localparam int   DEF_DEBOUNCE_CYCLES = 4;
  localparam int   DEF_CNT_W           = 8;
  localparam logic DEF_INIT_LEVEL      = 1'b0;

endpackage

// File: rtl/toggle_decoder_sync_chain.sv
// Multi-flop synchronizer with a configurable reset value, for any asynchronous
// single-bit input.
module sync_chain #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) sr <= {STAGES{INIT}};
    else       sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/toggle_decoder.sv
// Toggle-encoded event decoder: synchronize, optionally debounce
// (TOGGLE_DECODER_DEBOUNCE_EN), then pulse / pending / count / overrun.
module toggle_decoder
  import toggle_decoder_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int   CNT_W           = DEF_CNT_W,
  parameter logic INIT_LEVEL      = DEF_INIT_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tog_in,
  input  logic             ack,
  input  logic             clr,
  output logic             event_pulse,
  output logic             pending,
  output logic             level,
  output logic [CNT_W-1:0] count,
  output logic             overrun
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("toggle_decoder: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic s;
  logic accept;

  sync_chain #(
    .STAGES(SYNC_STAGES),
    .INIT  (INIT_LEVEL)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (tog_in),
    .q    (s)
  );

`ifdef TOGGLE_DECODER_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  state_t        state, state_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // dcnt counts consecutive samples where s disagrees with the accepted level
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (s != level) begin
          if (DEBOUNCE_CYCLES == 1) begin
            accept = 1'b1;
          end else begin
            state_nxt = CONFIRM;
            dcnt_nxt  = DW'(1);
          end
        end
      end
      CONFIRM: begin
        if (s == level) begin
          state_nxt = IDLE;
          dcnt_nxt  = '0;
        end else if (int'(dcnt) + 1 == DEBOUNCE_CYCLES) begin
          accept    = 1'b1;
          state_nxt = IDLE;
          dcnt_nxt  = '0;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        dcnt_nxt  = '0;
      end
    endcase
  end
`else
  always_comb begin
    accept = (s != level);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      event_pulse <= 1'b0;
      pending     <= 1'b0;
      level       <= INIT_LEVEL;
      count       <= '0;
      overrun     <= 1'b0;
    end else begin
      event_pulse <= accept;
      if (accept) level <= s;

      if (accept)   pending <= 1'b1;
      else if (ack) pending <= 1'b0;

      // increment lands on top of a same-cycle clear
      if (clr)         count <= accept ? CNT_W'(1) : '0;
      else if (accept) count <= count + CNT_W'(1);

      if (clr)                             overrun <= 1'b0;
      else if (accept && pending && !ack)  overrun <= 1'b1;
    end
  end

endmodule
